// File: rtl/imm_pkg.sv
// +----------------------------------------------------------------------------+
// | imm_pkg : shared widths, FSM states and chunk helper for imm_chunker       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package imm_pkg;

    localparam int DATA_W = 8;
    localparam int IMM_W  = 3;
    localparam int NCHUNK = (DATA_W + IMM_W - 1) / IMM_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    typedef logic [1:0] cidx_t;

    // Top chunk is narrower than IMM_W; the zero pad lands in its upper bits.
    function automatic logic [IMM_W-1:0] chunk_of(input logic [DATA_W-1:0] d,
                                                   input cidx_t k);
        logic [NCHUNK*IMM_W-1:0] pad;
        pad = {{(NCHUNK*IMM_W-DATA_W){1'b0}}, d};
        return pad[k*IMM_W +: IMM_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_chunk_count.sv
// +----------------------------------------------------------------------------+
// | imm_chunk_count : number of 3-bit chunks needed to rebuild an operand      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module imm_chunk_count
    import imm_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output cidx_t             o_count
);

    // Zero still needs one chunk, so the count starts at 1.
    always_comb begin
        o_count = cidx_t'(1);
        for (int k = 1; k < NCHUNK; k++) begin
            if (chunk_of(i_data, cidx_t'(k)) != '0) begin
                o_count = cidx_t'(k + 1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/imm_chunker.sv
// +----------------------------------------------------------------------------+
// | imm_chunker : serialises an operand into MSB-first 3-bit immediates        |
// | Build option: STRICT_IMM_EN (single beat, err on dropped upper bits)       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module imm_chunker
    import imm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_first,
    output logic              out_last,
    output logic              err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    cidx_t             r_idx;
    cidx_t             r_top;
    logic              r_err;
    cidx_t             w_top;
    logic              w_err;
    logic              w_accept;

`ifdef STRICT_IMM_EN
    assign w_top = '0;
    assign w_err = |in_data[DATA_W-1:IMM_W];
`else
    cidx_t w_count;

    imm_chunk_count u_count (
        .i_data  (in_data),
        .o_count (w_count)
    );

    assign w_top = w_count - cidx_t'(1);
    assign w_err = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_imm     = '0;
        out_first   = 1'b0;
        out_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_imm   = chunk_of(r_data, r_idx);
                out_first = (r_idx == r_top);
                out_last  = (r_idx == '0);
                if (out_ready && (r_idx == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // err is only ever high in the cycle right after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_idx  <= '0;
            r_top  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_data <= in_data;
                r_idx  <= w_top;
                r_top  <= w_top;
                r_err  <= w_err;
            end else if ((r_state == ST_EMIT) && out_ready && (r_idx != '0)) begin
                r_idx <= r_idx - cidx_t'(1);
            end
        end
    end

    assign err = r_err;

endmodule

`default_nettype wire
